// File: rtl/mult_pkg.sv
// Shared constants for the sequential multiplier and its divider companion.
package mult_pkg;

  // Default operand width, shared with the restoring divider.
  localparam int DEFAULT_WIDTH = 4;

  // FSM state encoding. Kept as plain constants so it matches the divider.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_ADD   = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_END   = 3'd4;

endpackage

// File: rtl/multiplicador_dp.sv
// Shift-and-add datapath: operand registers, accumulator, bit counter and adder.
// The FSM in the top level drives it through load/add/shift strobes.
module multiplicador_dp #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] sw_i,
  input  logic               load_i,
  input  logic               add_en_i,
  input  logic               sh_en_i,
  output logic               mplier_lsb_o,
  output logic               last_o,
  output logic [2*WIDTH-1:0] acc_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;

  // Operand latch on load, accumulate on add, advance one bit on shift.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is a single flop (no memory array), so all of
    // them are cleared by reset; an aborted operation leaves nothing behind.
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (load_i) begin
      // NOTE: non-blocking assignments so every register sees the values from
      // before this edge, independent of statement order.
      mcand_q  <= {{WIDTH{1'b0}}, sw_i[2*WIDTH-1:WIDTH]};
      mplier_q <= sw_i[WIDTH-1:0];
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      // The product fits in 2W bits, so the wrap of this add never triggers.
      if (add_en_i) acc_q <= acc_q + mcand_q;
      if (sh_en_i) begin
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + 1'b1;
      end
    end
  end

  assign mplier_lsb_o = mplier_q[0];
  assign last_o       = (cnt_q == CW'(WIDTH - 1));
  assign acc_o        = acc_q;

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential unsigned shift-and-add multiplier with init/done handshake.
// Holds the control FSM and the registered outputs; arithmetic lives in the datapath.
module multiplicador_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*WIDTH-1:0] SW,
  input  logic               init,
  output logic [2*WIDTH-1:0] resultado,
  output logic               done,
  output logic               busy
);

  logic [2:0]         state_q, state_d;
  logic               load, add_en, sh_en;
  logic               mplier_lsb, last;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] resultado_q;
  logic               done_q, busy_q;

  multiplicador_dp #(.WIDTH(WIDTH)) u_dp (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_i         (SW),
    .load_i       (load),
    .add_en_i     (add_en),
    .sh_en_i      (sh_en),
    .mplier_lsb_o (mplier_lsb),
    .last_o       (last),
    .acc_o        (acc)
  );

  // Next-state and datapath strobes. init is only looked at in IDLE, which is
  // what makes a request during an operation harmless.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch forms.
    state_d = state_q;
    load    = 1'b0;
    add_en  = 1'b0;
    sh_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (init) begin
          load    = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: state_d = mplier_lsb ? ST_ADD : ST_SHIFT;
      ST_ADD: begin
        add_en  = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sh_en   = 1'b1;
        state_d = last ? ST_END : ST_CHECK;
      end
      ST_END:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Output registers: product captured and done pulsed on END; busy spans the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resultado_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      done_q <= (state_q == ST_END);
      if (state_q == ST_END) begin
        resultado_q <= acc;
        busy_q      <= 1'b0;
      end else if (load) begin
        busy_q <= 1'b1;
      end
    end
  end

  assign resultado = resultado_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Self-checking bench for multiplicador_seq (WIDTH=4): directed corner cases
// plus random operands, checked against an arithmetic reference model.
module tb_multiplicador_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [2*W-1:0] sw;
  logic           init;
  logic [2*W-1:0] resultado;
  logic           done;
  logic           busy;

  int tests_run = 0;
  int tests_failed = 0;

  multiplicador_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SW        (sw),
    .init      (init),
    .resultado (resultado),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: product by plain arithmetic, latency from the step count
  // (two steps per bit, one extra per set multiplier bit, one for END).
  function automatic logic [31:0] ref_prod(input logic [2*W-1:0] v);
    return 32'(v[2*W-1:W]) * 32'(v[W-1:0]);
  endfunction

  function automatic int ref_lat(input logic [2*W-1:0] v);
    logic [W-1:0] b;
    b = v[W-1:0];
    return 2 * W + $countones(b) + 1;
  endfunction

  // done and busy must never overlap.
  always @(negedge clk) check("done_busy_excl", 32'(done & busy), 32'd0);

  // One full operation from IDLE: pulse init, count edges to done, check all.
  task automatic run_op(input logic [2*W-1:0] sw_v, input string tag);
    int lat = -1;
    int busy_low = 0;
    @(negedge clk);
    sw   = sw_v;
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (done) lat = n;
      else if (!busy) busy_low++;
    end
    check({tag, "_latency"}, lat, ref_lat(sw_v));
    check({tag, "_result"}, 32'(resultado), ref_prod(sw_v));
    check({tag, "_busy_gap"}, busy_low, 0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(resultado), ref_prod(sw_v));
  endtask

  initial begin
    int first_done;
    int n_done;
    int prev_done;
    int n;

    rst_n = 1'b0;
    sw    = '0;
    init  = 1'b0;
    #1;
    check("reset_resultado", 32'(resultado), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed: largest operands, mixed, zero multiplicand, zero multiplier.
    run_op(8'hFF, "ff");
    run_op(8'h35, "x35");
    run_op(8'h09, "x09");
    run_op(8'h70, "x70");

    // init and SW changes during an operation are ignored.
    @(negedge clk);
    sw = 8'h67; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    first_done = -1; n_done = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done) begin
        n_done++;
        if (first_done < 0) first_done = k;
      end
      if (k == 3) begin
        #4 sw = 8'hFF; init = 1'b1;
      end
      if (k == 4) init = 1'b0;
    end
    check("busy_ignore_count", n_done, 1);
    check("busy_ignore_latency", first_done, ref_lat(8'h67));
    check("busy_ignore_result", 32'(resultado), 32'h2A);

    // Asynchronous reset mid-operation aborts it with no done pulse.
    @(negedge clk);
    sw = 8'hFF; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_resultado", 32'(resultado), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_result_kept", 32'(resultado), 32'd0);

    // Reset released with init high, then init held: back-to-back operations.
    // Each new op is accepted on the IDLE edge right after done, so successive
    // dones are latency+1 edges apart.
    @(negedge clk);
    rst_n = 1'b0;
    sw    = 8'h23;
    init  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n = 0; n_done = 0; prev_done = 0;
    while (n_done < 3 && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        check("hold_result", 32'(resultado), 32'h06);
        if (n_done == 0) check("hold_first_latency", n, ref_lat(8'h23));
        else             check("hold_spacing", n - prev_done, ref_lat(8'h23) + 1);
        prev_done = n;
        n_done++;
        if (n_done == 3) init = 1'b0;
      end
    end
    check("hold_done_count", n_done, 3);
    init = 1'b0;
    repeat (2) @(posedge clk);

    // Randomized operands.
    for (int i = 0; i < 30; i++) begin
      run_op(8'($urandom_range(0, 255)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
